// File: rtl/bp_fe_icache_cce_responder.sv
// bp_fe_icache_cce_responder
//   CCE-side responder for a single I-cache LCE. It accepts one LCE miss
//   request at a time, fetches the block through a simple memory port and
//   answers with LCE commands: set_tag + data for cached reads (then it waits
//   for the coherence ack), or a single uc_data for uncached reads.
//
//   The processor config values (address, id, block and associativity widths)
//   are exposed as individual parameters.
//
//   Message layouts, MSB first:
//     req  : {msg_type[1:0], src_id, lru_way_id, addr}
//     cmd  : {msg_type[2:0], dst_id, src_id(cce), way_id, state[1:0], addr, data}
//     resp : {msg_type[1:0], src_id, addr}
//
// Ports
//   clk_i, reset_n_i                     clock, async active-low reset
//   lce_req_i / _v_i / _yumi_o           request from the LCE
//   lce_cmd_o / _v_o / _ready_i          command to the LCE (registered)
//   lce_resp_i / _v_i / _yumi_o          response from the LCE
//   mem_addr_o / mem_v_o / mem_ready_i   block-aligned fetch request
//   mem_data_i / mem_v_i                 returned block, single-cycle pulse
//   busy_o                               transaction in flight
//   error_o                              sticky: timeout or unexpected response
//
// state       | meaning
// ------------+---------------------------------------------------------
// e_ready     | idle, accepting a request
// e_mem_req   | fetch request presented to memory
// e_mem_wait  | waiting for the block, timeout counter running
// e_send_tag  | set_tag command offered to the LCE
// e_send_data | data command offered to the LCE
// e_send_uc   | uc_data command offered to the LCE
// e_wait_ack  | waiting for the coherence ack
module bp_fe_icache_cce_responder
  #(parameter int paddr_width_p      = 40
    , parameter int lce_id_width_p     = 2
    , parameter int cce_id_width_p     = 2
    , parameter int cce_block_width_p  = 512
    , parameter int icache_lce_assoc_p = 8
    , parameter int cce_id_p           = 0
    , parameter int mem_timeout_p      = 1023
    , localparam int way_id_width_lp       = $clog2(icache_lce_assoc_p)
    , localparam int lce_cce_req_width_lp  = 2 + lce_id_width_p + way_id_width_lp + paddr_width_p
    , localparam int lce_cmd_width_lp      = 3 + lce_id_width_p + cce_id_width_p + way_id_width_lp
                                             + 2 + paddr_width_p + cce_block_width_p
    , localparam int lce_cce_resp_width_lp = 2 + lce_id_width_p + paddr_width_p
    )
   (input  logic                             clk_i
    , input  logic                             reset_n_i
    , input  logic [lce_cce_req_width_lp-1:0]  lce_req_i
    , input  logic                             lce_req_v_i
    , output logic                             lce_req_yumi_o
    , output logic [lce_cmd_width_lp-1:0]      lce_cmd_o
    , output logic                             lce_cmd_v_o
    , input  logic                             lce_cmd_ready_i
    , input  logic [lce_cce_resp_width_lp-1:0] lce_resp_i
    , input  logic                             lce_resp_v_i
    , output logic                             lce_resp_yumi_o
    , output logic [paddr_width_p-1:0]         mem_addr_o
    , output logic                             mem_v_o
    , input  logic                             mem_ready_i
    , input  logic [cce_block_width_p-1:0]     mem_data_i
    , input  logic                             mem_v_i
    , output logic                             busy_o
    , output logic                             error_o
    );

    localparam int blk_off_lp   = $clog2(cce_block_width_p / 8);
    localparam int word_sel_lp  = blk_off_lp - 3;
    localparam int cnt_width_lp = $clog2(mem_timeout_p + 1);

    localparam logic [1:0] e_lce_req_type_uc_rd = 2'd1;
    localparam logic [2:0] e_lce_cmd_set_tag    = 3'd0;
    localparam logic [2:0] e_lce_cmd_data       = 3'd1;
    localparam logic [2:0] e_lce_cmd_uc_data    = 3'd2;
    localparam logic [1:0] e_coh_i              = 2'd0;
    localparam logic [1:0] e_coh_s              = 2'd1;
    localparam logic [1:0] e_lce_cce_coh_ack    = 2'd0;
    localparam logic [cce_id_width_p-1:0] cce_id_lp = cce_id_width_p'(cce_id_p);

    typedef enum logic [2:0] {
        e_ready, e_mem_req, e_mem_wait, e_send_tag, e_send_data, e_send_uc, e_wait_ack
    } state_e;

    state_e                            state_r;
    logic [lce_cce_req_width_lp-1:0]   req_r;
    logic [cce_block_width_p-1:0]      data_r;
    logic [cnt_width_lp-1:0]           cnt_r;
    logic [lce_cmd_width_lp-1:0]       cmd_r;
    logic                              cmd_v_r;
    logic                              mem_v_r;
    logic                              busy_r;
    logic                              error_r;

    logic [paddr_width_p-1:0]          req_addr;
    logic [way_id_width_lp-1:0]        req_way;
    logic [lce_id_width_p-1:0]         req_src;
    logic [1:0]                        req_type;
    logic [1:0]                        resp_type;
    logic [lce_id_width_p-1:0]         resp_src;
    logic [word_sel_lp-1:0]            word_sel;
    logic [63:0]                       uc_word;
    logic                              ack_ok;
    logic                              unused_resp_addr;

    assign req_addr  = req_r[paddr_width_p-1:0];
    assign req_way   = req_r[paddr_width_p +: way_id_width_lp];
    assign req_src   = req_r[paddr_width_p + way_id_width_lp +: lce_id_width_p];
    assign req_type  = req_r[lce_cce_req_width_lp-1 -: 2];
    assign resp_type = lce_resp_i[lce_cce_resp_width_lp-1 -: 2];
    assign resp_src  = lce_resp_i[paddr_width_p +: lce_id_width_p];
    assign ack_ok    = (resp_type == e_lce_cce_coh_ack) && (resp_src == req_src);
    assign unused_resp_addr = ^lce_resp_i[paddr_width_p-1:0];

    // The uncached word is picked straight off the memory bus because the
    // command is built in the same cycle the block arrives.
    assign word_sel = req_addr[blk_off_lp-1:3];
    assign uc_word  = mem_data_i[word_sel*64 +: 64];

    // A response arriving together with a request in READY is left pending.
    assign lce_req_yumi_o  = (state_r == e_ready) && lce_req_v_i;
    assign lce_resp_yumi_o = lce_resp_v_i
                             && ((state_r == e_wait_ack) || ((state_r == e_ready) && !lce_req_v_i));

    assign lce_cmd_o   = cmd_r;
    assign lce_cmd_v_o = cmd_v_r;
    assign mem_addr_o  = {req_addr[paddr_width_p-1:blk_off_lp], {blk_off_lp{1'b0}}};
    assign mem_v_o     = mem_v_r;
    assign busy_o      = busy_r;
    assign error_o     = error_r;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r <= e_ready;
            req_r   <= '0;
            data_r  <= '0;
            cnt_r   <= '0;
            cmd_r   <= '0;
            cmd_v_r <= 1'b0;
            mem_v_r <= 1'b0;
            busy_r  <= 1'b0;
            error_r <= 1'b0;
        end else begin
            case (state_r)
                e_ready: begin
                    if (lce_req_v_i) begin
                        req_r   <= lce_req_i;
                        mem_v_r <= 1'b1;
                        busy_r  <= 1'b1;
                        state_r <= e_mem_req;
                    end else if (lce_resp_v_i) begin
                        error_r <= 1'b1;
                    end
                end
                e_mem_req: begin
                    if (mem_ready_i) begin
                        mem_v_r <= 1'b0;
                        cnt_r   <= cnt_width_lp'(mem_timeout_p - 1);
                        state_r <= e_mem_wait;
                    end
                end
                e_mem_wait: begin
                    if (mem_v_i) begin
                        data_r  <= mem_data_i;
                        cmd_v_r <= 1'b1;
                        if (req_type == e_lce_req_type_uc_rd) begin
                            cmd_r   <= {e_lce_cmd_uc_data, req_src, cce_id_lp, req_way, e_coh_i, req_addr,
                                        {(cce_block_width_p-64){1'b0}}, uc_word};
                            state_r <= e_send_uc;
                        end else begin
                            cmd_r   <= {e_lce_cmd_set_tag, req_src, cce_id_lp, req_way, e_coh_s, req_addr,
                                        {cce_block_width_p{1'b0}}};
                            state_r <= e_send_tag;
                        end
                    end else if (cnt_r == '0) begin
                        error_r <= 1'b1;
                        busy_r  <= 1'b0;
                        state_r <= e_ready;
                    end else begin
                        cnt_r <= cnt_r - 1'b1;
                    end
                end
                e_send_tag: begin
                    if (lce_cmd_ready_i) begin
                        cmd_r   <= {e_lce_cmd_data, req_src, cce_id_lp, req_way, e_coh_s, req_addr, data_r};
                        state_r <= e_send_data;
                    end
                end
                e_send_data: begin
                    if (lce_cmd_ready_i) begin
                        cmd_v_r <= 1'b0;
                        state_r <= e_wait_ack;
                    end
                end
                e_send_uc: begin
                    if (lce_cmd_ready_i) begin
                        cmd_v_r <= 1'b0;
                        busy_r  <= 1'b0;
                        state_r <= e_ready;
                    end
                end
                e_wait_ack: begin
                    if (lce_resp_v_i) begin
                        if (!ack_ok) error_r <= 1'b1;
                        busy_r  <= 1'b0;
                        state_r <= e_ready;
                    end
                end
                default: state_r <= e_ready;
            endcase
        end
    end

endmodule

// File: tb/tb_bp_fe_icache_cce_responder.sv
// Directed + randomized bench for bp_fe_icache_cce_responder. Expected
// commands are assembled from the request fields and the returned block.
module tb_bp_fe_icache_cce_responder;

    localparam int pa_w   = 40;
    localparam int blk_w  = 512;
    localparam int req_w  = 47;
    localparam int cmd_w  = 564;
    localparam int resp_w = 44;
    localparam int tmo    = 15;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [req_w-1:0]  lce_req = '0;
    logic              req_v = 1'b0;
    logic              req_yumi;
    logic [cmd_w-1:0]  lce_cmd;
    logic              cmd_v;
    logic              cmd_ready = 1'b0;
    logic [resp_w-1:0] lce_resp = '0;
    logic              resp_v = 1'b0;
    logic              resp_yumi;
    logic [pa_w-1:0]   mem_addr;
    logic              mem_v_out;
    logic              mem_ready = 1'b0;
    logic [blk_w-1:0]  mem_data = '0;
    logic              mem_v_in = 1'b0;
    logic              busy;
    logic              error;

    int n_vec = 0;
    int n_err = 0;
    int cmd_hs = 0;
    logic exp_err = 1'b0;

    bp_fe_icache_cce_responder #(.mem_timeout_p(tmo)) dut (
        .clk_i(clk), .reset_n_i(rst_n),
        .lce_req_i(lce_req), .lce_req_v_i(req_v), .lce_req_yumi_o(req_yumi),
        .lce_cmd_o(lce_cmd), .lce_cmd_v_o(cmd_v), .lce_cmd_ready_i(cmd_ready),
        .lce_resp_i(lce_resp), .lce_resp_v_i(resp_v), .lce_resp_yumi_o(resp_yumi),
        .mem_addr_o(mem_addr), .mem_v_o(mem_v_out), .mem_ready_i(mem_ready),
        .mem_data_i(mem_data), .mem_v_i(mem_v_in),
        .busy_o(busy), .error_o(error));

    always #5 clk = ~clk;

    always @(posedge clk) if (rst_n && cmd_v && cmd_ready) cmd_hs <= cmd_hs + 1;

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic chk(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [blk_w-1:0] rand_blk();
        logic [blk_w-1:0] b;
        for (int i = 0; i < blk_w/32; i++) b[i*32 +: 32] = $urandom;
        return b;
    endfunction

    function automatic logic [cmd_w-1:0] mk_cmd(input logic [2:0] t, input logic [1:0] dst,
                                                input logic [2:0] way, input logic [1:0] st,
                                                input logic [pa_w-1:0] addr, input logic [blk_w-1:0] d);
        return {t, dst, 2'd0, way, st, addr, d};
    endfunction

    // Uncached word: the 64-bit word of the block at the address's offset.
    function automatic logic [63:0] blk_word(input logic [blk_w-1:0] blk, input logic [pa_w-1:0] addr);
        logic [blk_w-1:0] s;
        int w;
        w = int'(addr % 64) / 8;
        s = blk >> (w * 64);
        return s[63:0];
    endfunction

    task automatic do_reset();
        rst_n = 1'b0; req_v = 0; resp_v = 0; mem_ready = 0; mem_v_in = 0; cmd_ready = 0;
        exp_err = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic send_cmd(input string tag, input logic [cmd_w-1:0] c, input int bp);
        for (int i = 0; i < bp; i++) begin
            chk({tag, "_hold_v"}, cmd_v, 1'b1);
            chk({tag, "_hold"}, lce_cmd, c);
            tick();
        end
        chk({tag, "_v"}, cmd_v, 1'b1);
        chk(tag, lce_cmd, c);
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
    endtask

    // One transaction from request to return to READY. with_resp raises a
    // response together with the request; rst_in_data resets in SEND_DATA.
    task automatic do_txn(input bit uc, input logic [pa_w-1:0] addr, input logic [2:0] way,
                          input logic [1:0] src, input int lat, input int bp, input bit ack_ok,
                          input bit with_resp, input bit rst_in_data);
        logic [blk_w-1:0] blk;
        logic [cmd_w-1:0] c1, c2;
        int n0;
        blk = rand_blk();
        lce_req = {(uc ? 2'd1 : 2'd0), src, way, addr};
        req_v = 1'b1;
        if (with_resp) begin
            lce_resp = {2'd0, src, addr};
            resp_v = 1'b1;
        end
        #1;
        chk("req_yumi", req_yumi, 1'b1);
        if (with_resp) chk("resp_yumi_simul", resp_yumi, 1'b0);
        tick();
        req_v = 1'b0; resp_v = 1'b0;
        chk("mem_v", mem_v_out, 1'b1);
        chk("mem_addr", mem_addr, {addr[pa_w-1:6], 6'b0});
        chk("busy_set", busy, 1'b1);
        repeat ($urandom_range(0, 2)) begin
            tick();
            chk("mem_v_hold", mem_v_out, 1'b1);
        end
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        chk("mem_v_drop", mem_v_out, 1'b0);
        lce_resp = {2'd0, src, addr};
        resp_v = 1'b1;
        #1 chk("resp_yumi_wait", resp_yumi, 1'b0);
        resp_v = 1'b0;
        for (int i = 0; i < lat; i++) begin
            tick();
            chk("no_cmd_wait", cmd_v, 1'b0);
        end
        n0 = cmd_hs;
        mem_data = blk; mem_v_in = 1'b1;
        tick();
        mem_v_in = 1'b0; mem_data = rand_blk();
        if (uc) begin
            c1 = mk_cmd(3'd2, src, way, 2'd0, addr, {{(blk_w-64){1'b0}}, blk_word(blk, addr)});
            send_cmd("uc_cmd", c1, bp);
        end else begin
            c1 = mk_cmd(3'd0, src, way, 2'd1, addr, '0);
            c2 = mk_cmd(3'd1, src, way, 2'd1, addr, blk);
            send_cmd("tag_cmd", c1, bp);
            if (rst_in_data) begin
                chk("data_cmd_pre_rst", lce_cmd, c2);
                #2 rst_n = 1'b0;
                exp_err = 1'b0;
                #1;
                chk("rst_cmd_v", cmd_v, 1'b0);
                chk("rst_busy", busy, 1'b0);
                chk("rst_error", error, 1'b0);
                @(posedge clk); #1;
                rst_n = 1'b1;
                mem_data = blk; mem_v_in = 1'b1;
                tick();
                mem_v_in = 1'b0;
                chk("post_rst_cmd_v", cmd_v, 1'b0);
                chk("post_rst_busy", busy, 1'b0);
                return;
            end
            send_cmd("data_cmd", c2, bp);
            chk("ack_wait_cmd_v", cmd_v, 1'b0);
            chk("ack_wait_busy", busy, 1'b1);
            lce_resp = {2'd0, (ack_ok ? src : src ^ 2'd1), addr};
            resp_v = 1'b1;
            #1 chk("ack_yumi", resp_yumi, 1'b1);
            tick();
            resp_v = 1'b0;
            if (!ack_ok) exp_err = 1'b1;
        end
        chk("done_busy", busy, 1'b0);
        chk("done_cmd_v", cmd_v, 1'b0);
        chk("done_error", error, exp_err);
        chk("cmd_count", 32'(cmd_hs - n0), (uc ? 32'd1 : 32'd2));
    endtask

    initial begin
        #1;
        tick();
        chk("rst_req_yumi", req_yumi, 1'b0);
        chk("rst_resp_yumi", resp_yumi, 1'b0);
        chk("rst_cmd_v", cmd_v, 1'b0);
        chk("rst_mem_v", mem_v_out, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_error", error, 1'b0);
        do_reset();

        // cached miss, data after 3 cycles
        do_txn(1'b0, 40'h80_0000_0040, 3'd2, 2'd0, 3, 0, 1'b1, 1'b0, 1'b0);
        // uncached read of block word 1
        do_txn(1'b1, 40'h80_0000_0048, 3'd5, 2'd0, 2, 0, 1'b1, 1'b0, 1'b0);
        // backpressure on both cached commands
        do_txn(1'b0, {$urandom, 8'h00}, 3'd6, 2'd1, 1, 5, 1'b1, 1'b0, 1'b0);
        // block arrives on the last MEM_WAIT cycle before the timeout
        do_txn(1'b0, {$urandom, 8'h80}, 3'd1, 2'd3, tmo - 1, 0, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++)
            do_txn(1'($urandom_range(0, 1)), {$urandom, 8'($urandom)}, 3'($urandom_range(0, 7)),
                   2'($urandom_range(0, 3)), $urandom_range(0, tmo - 1), $urandom_range(0, 3),
                   1'b1, 1'b0, 1'b0);
        // ack from the wrong LCE
        do_txn(1'b0, {$urandom, 8'h40}, 3'd4, 2'd2, 0, 1, 1'b0, 1'b0, 1'b0);

        // timeout: no block ever returned
        do_reset();
        lce_req = {2'd0, 2'd1, 3'd3, 40'h12_3456_7880};
        req_v = 1'b1;
        #1 chk("to_req_yumi", req_yumi, 1'b1);
        tick();
        req_v = 1'b0;
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        for (int i = 1; i < tmo; i++) begin
            tick();
            chk("to_error_early", error, 1'b0);
            chk("to_no_cmd", cmd_v, 1'b0);
        end
        tick();
        exp_err = 1'b1;
        chk("to_error", error, 1'b1);
        chk("to_busy", busy, 1'b0);
        chk("to_no_cmd_end", cmd_v, 1'b0);
        do_txn(1'b0, {$urandom, 8'hc0}, 3'd0, 2'd1, 2, 1, 1'b1, 1'b0, 1'b0);

        // stray response in READY, then request with a simultaneous response
        do_reset();
        lce_resp = {2'd0, 2'd0, 40'h0};
        resp_v = 1'b1;
        #1;
        chk("stray_yumi", resp_yumi, 1'b1);
        chk("stray_req_yumi", req_yumi, 1'b0);
        tick();
        resp_v = 1'b0;
        exp_err = 1'b1;
        chk("stray_error", error, 1'b1);
        do_txn(1'b1, {$urandom, 8'h18}, 3'd7, 2'd2, 1, 0, 1'b1, 1'b1, 1'b0);

        // reset while the data command is pending
        do_txn(1'b0, {$urandom, 8'h00}, 3'd2, 2'd1, 1, 2, 1'b1, 1'b0, 1'b1);
        do_txn(1'b0, {$urandom, 8'h40}, 3'd3, 2'd0, 1, 0, 1'b1, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
